// File: rtl/imm_pkg.sv
// Shared constants and buffer state encoding for the immediate narrower.
package imm_pkg;

  localparam int DATA_W = 8;
  localparam int IMM_W  = 5;

  localparam logic signed [IMM_W-1:0] IMM_MAX = 5'sd15;
  localparam logic signed [IMM_W-1:0] IMM_MIN = -5'sd16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_fit.sv
// Combinational fit test for narrowing a signed value, with saturate or truncate on overflow.
module imm_fit
  import imm_pkg::*;
#(
  parameter int IN_W  = DATA_W,
  parameter int OUT_W = IMM_W,
  parameter bit SAT   = 1'b1
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             ovf_o
);

  logic [IN_W-OUT_W:0] hi;
  logic                fits;

  // The value fits when every bit from the output sign bit upward is a copy of it.
  assign hi    = din_i[IN_W-1:OUT_W-1];
  assign fits  = (&hi) | ~(|hi);
  assign ovf_o = ~fits;

  generate
    if (SAT) begin : g_sat
      always_comb begin
        dout_o = din_i[OUT_W-1:0];
        if (!fits) begin
          dout_o = din_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end else begin : g_trunc
      assign dout_o = din_i[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/imm_narrow.sv
// Signed immediate narrower with valid/ready on both sides and a 2-entry skid buffer.
// Optional overflow counter (clr_cnt/ovf_cnt ports) enabled by defining IMM_NARROW_OVF_CNT_EN.
module imm_narrow
  import imm_pkg::*;
#(
  parameter int IN_W  = DATA_W,
  parameter int OUT_W = IMM_W,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             ovf
`ifdef IMM_NARROW_OVF_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [7:0]       ovf_cnt
`endif
);

  buf_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] head_dout_q, head_dout_d, skid_dout_q, skid_dout_d;
  logic             head_ovf_q, head_ovf_d, skid_ovf_q, skid_ovf_d;
  logic [OUT_W-1:0] fit_dout;
  logic             fit_ovf;
  logic             acc, drn;

  imm_fit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_fit (
    .din_i  (din),
    .dout_o (fit_dout),
    .ovf_o  (fit_ovf)
  );

  assign acc = in_valid & in_ready_q;
  assign drn = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d     = state_q;
    head_dout_d = head_dout_q;
    head_ovf_d  = head_ovf_q;
    skid_dout_d = skid_dout_q;
    skid_ovf_d  = skid_ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d     = ONE;
          head_dout_d = fit_dout;
          head_ovf_d  = fit_ovf;
        end
      end
      ONE: begin
        if (acc && !drn) begin
          state_d     = FULL;
          skid_dout_d = fit_dout;
          skid_ovf_d  = fit_ovf;
        end else if (drn && !acc) begin
          state_d = EMPTY;
        end else if (acc && drn) begin
          head_dout_d = fit_dout;
          head_ovf_d  = fit_ovf;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can move the buffer.
        if (drn) begin
          state_d     = ONE;
          head_dout_d = skid_dout_q;
          head_ovf_d  = skid_ovf_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      head_dout_q <= '0;
      head_ovf_q  <= 1'b0;
      skid_dout_q <= '0;
      skid_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      head_dout_q <= head_dout_d;
      head_ovf_q  <= head_ovf_d;
      skid_dout_q <= skid_dout_d;
      skid_ovf_q  <= skid_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign dout      = head_dout_q;
  assign ovf       = head_ovf_q;

`ifdef IMM_NARROW_OVF_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (drn && head_ovf_q && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_narrow.sv
// Scoreboard bench for imm_narrow: one saturating and one truncating instance share stimulus.
`timescale 1ns/1ps
module tb_imm_narrow;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] din = '0;
  logic       in_ready_s, out_valid_s, ovf_s;
  logic       in_ready_t, out_valid_t, ovf_t;
  logic [4:0] dout_s, dout_t;
`ifdef IMM_NARROW_OVF_CNT_EN
  logic       clr_cnt = 1'b0;
  logic [7:0] cnt_s, cnt_t;
  int         cnt_model = 0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] ds;
    logic       os;
    logic [4:0] dt;
    logic       ot;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  imm_narrow #(.IN_W(8), .OUT_W(5), .SAT(1'b1)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .din       (din),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .dout      (dout_s),
    .ovf       (ovf_s)
`ifdef IMM_NARROW_OVF_CNT_EN
    ,
    .clr_cnt   (clr_cnt),
    .ovf_cnt   (cnt_s)
`endif
  );

  imm_narrow #(.IN_W(8), .OUT_W(5), .SAT(1'b0)) u_trunc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_t),
    .din       (din),
    .out_valid (out_valid_t),
    .out_ready (out_ready),
    .dout      (dout_t),
    .ovf       (ovf_t)
`ifdef IMM_NARROW_OVF_CNT_EN
    ,
    .clr_cnt   (clr_cnt),
    .ovf_cnt   (cnt_t)
`endif
  );

  // Reference: range test on the integer value, clamp to [-16,15] or keep the low 5 bits.
  function automatic exp_t model(logic [7:0] d);
    exp_t e;
    int   v;
    v    = int'($signed(d));
    e.os = (v > 15) || (v < -16);
    e.ot = e.os;
    e.dt = d[4:0];
    if (!e.os)      e.ds = d[4:0];
    else if (v > 0) e.ds = 5'd15;
    else            e.ds = 5'b10000;
    return e;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: occupancy, head contents and handshake checked each cycle away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid_s", 8'(out_valid_s), 8'(sbq.size() != 0));
      chk("out_valid_t", 8'(out_valid_t), 8'(sbq.size() != 0));
      chk("in_ready_s", 8'(in_ready_s), 8'(sbq.size() < 2));
      chk("in_ready_t", 8'(in_ready_t), 8'(sbq.size() < 2));
`ifdef IMM_NARROW_OVF_CNT_EN
      chk("ovf_cnt_s", cnt_s, 8'(cnt_model));
      chk("ovf_cnt_t", cnt_t, 8'(cnt_model));
      if (clr_cnt) cnt_model = 0;
      else if (out_ready && sbq.size() != 0 && sbq[0].os && cnt_model < 255) cnt_model++;
`endif
      if (sbq.size() != 0) begin
        chk("dout_sat", 8'(dout_s), 8'(sbq[0].ds));
        chk("ovf_sat", 8'(ovf_s), 8'(sbq[0].os));
        chk("dout_trunc", 8'(dout_t), 8'(sbq[0].dt));
        chk("ovf_trunc", 8'(ovf_t), 8'(sbq[0].ot));
        if (out_ready) void'(sbq.pop_front());
      end
      if (in_valid && in_ready_s) sbq.push_back(model(din));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d);
    int   n;
    logic hs;
    n        = 0;
    hs       = 1'b0;
    in_valid = 1'b1;
    din      = d;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready_s;
      step();
      n++;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL send_timeout: din %0h never accepted", d);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words left, expected 0", sbq.size());
    end
  endtask

  task automatic mid_reset();
    in_valid  = 1'b1;
    din       = 8'h7F;
    out_ready = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 8'(out_valid_s), 8'd0);
    chk("rst_in_ready", 8'(in_ready_s), 8'd1);
    chk("rst_dout", 8'(dout_s), 8'd0);
    chk("rst_ovf", 8'(ovf_s), 8'd0);
    sbq.delete();
    in_valid = 1'b0;
`ifdef IMM_NARROW_OVF_CNT_EN
    cnt_model = 0;
    clr_cnt   = 1'b0;
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  logic [7:0] dir_vec[] = '{8'h05, 8'h7F, 8'h80, 8'hF0, 8'hEF, 8'h30,
                            8'h0F, 8'h10, 8'h00, 8'hFF, 8'hE0, 8'h1F};

  initial begin
    int   sent;
    int   guard;
    bit   did_reset;
    logic hs;

    #12;
    chk("init_out_valid", 8'(out_valid_s), 8'd0);
    chk("init_in_ready", 8'(in_ready_s), 8'd1);
    chk("init_dout", 8'(dout_s), 8'd0);
    chk("init_ovf", 8'(ovf_s), 8'd0);
    #5 rst_n = 1'b1;
    step();

    // Back-to-back directed words, including both range boundaries.
    out_ready = 1'b1;
    foreach (dir_vec[i]) send(dir_vec[i]);
    wait_drain();

    // Stall: two words fill the buffer, the third waits for out_ready.
    out_ready = 1'b0;
    send(8'h01);
    send(8'h02);
    in_valid = 1'b1;
    din      = 8'h03;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 8'(in_ready_s), 8'd0);
      step();
    end
    out_ready = 1'b1;
    send(8'h03);
    wait_drain();

    // Random valid/ready traffic with one asynchronous reset in the middle.
    sent      = 0;
    guard     = 0;
    did_reset = 1'b0;
    in_valid  = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        din = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 47) - 24);
      end
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef IMM_NARROW_OVF_CNT_EN
      clr_cnt = ($urandom_range(0, 49) == 0);
`endif
      @(negedge clk);
      hs = in_valid && in_ready_s;
      step();
      guard++;
      if (hs) begin
        sent++;
        in_valid = 1'b0;
      end
      if (sent == 500 && !did_reset) begin
        did_reset = 1'b1;
        mid_reset();
      end
    end
    checks++;
    if (sent < 1000) begin
      errors++;
      $display("FAIL random_words: sent %0d expected 1000", sent);
    end
`ifdef IMM_NARROW_OVF_CNT_EN
    clr_cnt = 1'b0;
`endif
    wait_drain();

`ifdef IMM_NARROW_OVF_CNT_EN
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    repeat (3) send(8'h7F);
    wait_drain();
    @(negedge clk);
    chk("cnt_three", cnt_s, 8'd3);
    step();
    out_ready = 1'b0;
    send(8'h80);
    clr_cnt   = 1'b1;
    out_ready = 1'b1;
    step();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("cnt_clear_wins", cnt_s, 8'd0);
    step();
    repeat (300) send(8'h80);
    wait_drain();
    @(negedge clk);
    chk("cnt_saturate", cnt_s, 8'd255);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
